// File: rtl/proc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : proc_ctrl_fsm
// Purpose  : Instruction sequencer for a small bus-based processor datapath.
//            Accepts one 9-bit instruction per run handshake in IDLE, then
//            steps it through T1..T3. Each step drives at most one bus source
//            and the matching load enables, and the last step pulses done.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NREG        : number of general registers (must be 8; fields are 3 bits)
// Ports
//   clk         : rising-edge clock, shared with the datapath
//   rst_n       : asynchronous active-low reset
//   run         : start request, sampled only in IDLE
//   instr[8:0]  : {opcode[2:0], Rx[2:0], Ry[2:0]}
//   ext_data_en : drive external data onto the bus
//   reg_in_en   : one-hot register load enable (R0..R7)
//   reg_out_en  : one-hot register bus-drive enable (R0..R7)
//   alu_reg_en  : load ALU operand register A from the bus
//   alu_sel     : ALU op, 0 = A+bus, 1 = A-bus
//   g_reg_en    : load result register G from the ALU
//   alu_out_en  : drive G onto the bus
//   busy        : high in T1..T3
//   done        : one-cycle pulse in the final step of an instruction
//   illegal     : one-cycle pulse for opcodes 1xx (optional feature)
// Build option
//   PROC_CTRL_ILLEGAL_FLAG_EN : when defined, opcodes 1xx pulse illegal
//                               together with done; otherwise illegal = 0.
// ============================================================================
module proc_ctrl_fsm #(
    parameter int NREG = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic [8:0]      instr,
    output logic            ext_data_en,
    output logic [NREG-1:0] reg_in_en,
    output logic [NREG-1:0] reg_out_en,
    output logic            alu_reg_en,
    output logic            alu_sel,
    output logic            g_reg_en,
    output logic            alu_out_en,
    output logic            busy,
    output logic            done,
    output logic            illegal
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_T1   = 2'd1;
    localparam logic [1:0] c_ST_T2   = 2'd2;
    localparam logic [1:0] c_ST_T3   = 2'd3;

    localparam logic [2:0] c_OP_MV  = 3'b000;
    localparam logic [2:0] c_OP_MVI = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_SUB = 3'b011;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [8:0]      r_ir;

    logic [2:0]      w_opcode;
    logic [2:0]      w_rx;
    logic [2:0]      w_ry;
    logic            w_is_alu_op;
    logic [NREG-1:0] w_rx_onehot;
    logic [NREG-1:0] w_ry_onehot;

    assign w_opcode    = r_ir[8:6];
    assign w_rx        = r_ir[5:3];
    assign w_ry        = r_ir[2:0];
    // add and sub share the three-step sequence; opcode bit 0 picks the op
    assign w_is_alu_op = (w_opcode == c_OP_ADD) || (w_opcode == c_OP_SUB);
    assign w_rx_onehot = {{(NREG-1){1'b0}}, 1'b1} << w_rx;
    assign w_ry_onehot = {{(NREG-1){1'b0}}, 1'b1} << w_ry;

    // ------------------------------------------------------------------------
    // State and instruction registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir <= 9'd0;
        end else if ((r_state == c_ST_IDLE) && run) begin
            r_ir <= instr;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: w_state_nxt = run ? c_ST_T1 : c_ST_IDLE;
            c_ST_T1:   w_state_nxt = w_is_alu_op ? c_ST_T2 : c_ST_IDLE;
            c_ST_T2:   w_state_nxt = c_ST_T3;
            c_ST_T3:   w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode: purely a function of (state, IR). Each step selects at
    // most one bus source, so bus exclusivity holds by construction.
    // ------------------------------------------------------------------------
    always_comb begin
        ext_data_en = 1'b0;
        reg_in_en   = '0;
        reg_out_en  = '0;
        alu_reg_en  = 1'b0;
        alu_sel     = 1'b0;
        g_reg_en    = 1'b0;
        alu_out_en  = 1'b0;
        done        = 1'b0;
        case (r_state)
            c_ST_T1: begin
                if (w_opcode == c_OP_MV) begin
                    reg_out_en = w_ry_onehot;
                    reg_in_en  = w_rx_onehot;
                    done       = 1'b1;
                end else if (w_opcode == c_OP_MVI) begin
                    ext_data_en = 1'b1;
                    reg_in_en   = w_rx_onehot;
                    done        = 1'b1;
                end else if (w_is_alu_op) begin
                    reg_out_en = w_rx_onehot;
                    alu_reg_en = 1'b1;
                end else begin
                    // opcodes 1xx complete as a one-cycle no-op
                    done = 1'b1;
                end
            end
            c_ST_T2: begin
                if (w_is_alu_op) begin
                    reg_out_en = w_ry_onehot;
                    g_reg_en   = 1'b1;
                    alu_sel    = w_opcode[0];
                end
            end
            c_ST_T3: begin
                if (w_is_alu_op) begin
                    alu_out_en = 1'b1;
                    reg_in_en  = w_rx_onehot;
                    done       = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign busy = (r_state != c_ST_IDLE);

`ifdef PROC_CTRL_ILLEGAL_FLAG_EN
    assign illegal = (r_state == c_ST_T1) && w_opcode[2];
`else
    assign illegal = 1'b0;
`endif

endmodule
`default_nettype wire
